// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forward selects, multiply FSM states
// and the legal range of the multiply latency.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_e;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 15;

  // Memory stage has the younger value, so it wins over writeback.
  function automatic logic [1:0] fwd_sel(input logic       reg_write_m,
                                         input logic [3:0] wa3_m,
                                         input logic       reg_write_w,
                                         input logic [3:0] wa3_w,
                                         input logic [3:0] ra_e);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (reg_write_m && (wa3_m == ra_e)) sel = FWD_M;
    else if (reg_write_w && (wa3_w == ra_e)) sel = FWD_W;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_unit_mul_stall_fsm.sv
// Multi-cycle multiply tracker: holds execute for MUL_LAT-1 extra cycles
// while a multiply occupies it.
module mul_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic MulOpE,
  output logic MulStall,
  output logic MulBusyE
);

  localparam logic [3:0] CNT_INIT = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;
  localparam bit         MULTI    = (MUL_LAT > 1);

  mul_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stall_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MUL_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    unique case (state_q)
      MUL_IDLE: begin
        if (MulOpE && MULTI) begin
          stall_d = 1'b1;
          state_d = MUL_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      MUL_BUSY: begin
        if (cnt_q != 4'd0) begin
          stall_d = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          state_d = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, independent of MulOpE.
  assign MulStall = stall_d & ~reset;
  assign MulBusyE = (state_q == MUL_BUSY) & ~reset;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, flush control and
// an optional multi-cycle multiply stall (enabled by HAZARD_MULTICYCLE_MUL_EN).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCWrPendingF,
  input  logic       PCSrcW,
  input  logic       BranchTakenD,
  input  logic       MulOpE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       MulBusyE
);

  logic       mul_stall;
  logic       mul_busy;
  logic       ld_stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

`ifdef HAZARD_MULTICYCLE_MUL_EN
  mul_stall_fsm #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_fsm (
    .clk      (clk),
    .reset    (reset),
    .MulOpE   (MulOpE),
    .MulStall (mul_stall),
    .MulBusyE (mul_busy)
  );
`else
  logic unused_mul_inputs;
  assign unused_mul_inputs = &{1'b0, clk, MulOpE};
  assign mul_stall = 1'b0;
  assign mul_busy  = 1'b0;
`endif

  assign fwd_a    = fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, RA1E);
  assign fwd_b    = fwd_sel(RegWriteM, WA3M, RegWriteW, WA3W, RA2E);
  assign ld_stall = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));

  // A multiply stall freezes decode/execute, so flushes must wait for it.
  always_comb begin
    ForwardAE = FWD_NONE;
    ForwardBE = FWD_NONE;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    MulBusyE  = 1'b0;
    if (!reset) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      StallF    = ld_stall | PCWrPendingF | mul_stall;
      StallD    = ld_stall | mul_stall;
      StallE    = mul_stall;
      FlushD    = (PCWrPendingF | PCSrcW | BranchTakenD) & ~mul_stall;
      FlushE    = (ld_stall | BranchTakenD) & ~mul_stall;
      MulBusyE  = mul_busy;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit; expectations adapt to whether
// HAZARD_MULTICYCLE_MUL_EN is defined.
module tb_hazard_unit;

`ifdef HAZARD_MULTICYCLE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] RA1D = 0, RA2D = 0, RA1E = 0, RA2E = 0, WA3E = 0, WA3M = 0, WA3W = 0;
  logic       RegWriteE = 0, RegWriteM = 0, RegWriteW = 0, MemtoRegE = 0;
  logic       PCWrPendingF = 0, PCSrcW = 0, BranchTakenD = 0, MulOpE = 0;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, MulBusyE;

  logic [9:0] exp_q[$];
  string      name_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  hazard_unit #(.MUL_LAT(3)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .BranchTakenD(BranchTakenD), .MulOpE(MulOpE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .MulBusyE(MulBusyE)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  // {FA, FB, StallF, StallD, StallE, FlushD, FlushE, MulBusyE}
  function automatic logic [9:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic sf, input logic sd, input logic se,
                                    input logic fd, input logic fe, input logic mb);
    return {fa, fb, sf, sd, se, fd, fe, mb};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCWrPendingF = 0; PCSrcW = 0; BranchTakenD = 0; MulOpE = 0;
  endtask

  task automatic expect_out(input logic [9:0] e, input string name);
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Monitor / scoreboard: one expectation consumed per cycle, mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [9:0] e, a;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, MulBusyE};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got FA=%b FB=%b SF=%b SD=%b SE=%b FD=%b FE=%b MB=%b, want FA=%b FB=%b SF=%b SD=%b SE=%b FD=%b FE=%b MB=%b",
                 nm, a[9:8], a[7:6], a[5], a[4], a[3], a[2], a[1], a[0],
                 e[9:8], e[7:6], e[5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // Stimulus
  initial begin
    step(); reset = 1; RA1E = 3; WA3M = 3; RegWriteM = 1; PCWrPendingF = 1; BranchTakenD = 1;
    expect_out(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0), "reset_outputs");

    step(); clear_in(); reset = 0;
    RA1E = 3; WA3M = 3; RegWriteM = 1; WA3W = 3; RegWriteW = 1;
    expect_out(mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0), "fwd_a_mem_wins");
    step(); RegWriteM = 0;
    expect_out(mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0), "fwd_a_wb");
    step(); RegWriteW = 0;
    expect_out(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0), "fwd_a_none");
    step(); clear_in(); RA1E = 7; RA2E = 15; WA3M = 15; RegWriteM = 1; WA3W = 15; RegWriteW = 1;
    expect_out(mk(2'b00, 2'b10, 0, 0, 0, 0, 0, 0), "fwd_b_r15_mem");
    step(); clear_in(); RA1E = 9; RA2E = 9; WA3M = 4; RegWriteM = 1; WA3W = 9; RegWriteW = 1;
    expect_out(mk(2'b01, 2'b01, 0, 0, 0, 0, 0, 0), "fwd_ab_wb");

    step(); clear_in(); MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5; RA1D = 0;
    expect_out(mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0), "ldstall_ra2");
    step(); RegWriteE = 0;
    expect_out(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0), "ldstall_no_regwrite");
    step(); RegWriteE = 1; RA1D = 5; RA2D = 1;
    expect_out(mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0), "ldstall_ra1");
    step(); MemtoRegE = 0;
    expect_out(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0), "ldstall_not_load");

    step(); clear_in(); PCWrPendingF = 1;
    expect_out(mk(2'b00, 2'b00, 1, 0, 0, 1, 0, 0), "pcwr_pending");
    step(); clear_in(); PCSrcW = 1;
    expect_out(mk(2'b00, 2'b00, 0, 0, 0, 1, 0, 0), "pcsrc_w");
    step(); clear_in(); BranchTakenD = 1;
    expect_out(mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0), "branch_taken");

    // Plain multiply, held three cycles
    step(); clear_in(); MulOpE = 1;
    expect_out(MUL_EN ? mk(0, 0, 1, 1, 1, 0, 0, 0) : mk(0, 0, 0, 0, 0, 0, 0, 0), "mul_c0");
    step();
    expect_out(MUL_EN ? mk(0, 0, 1, 1, 1, 0, 0, 1) : mk(0, 0, 0, 0, 0, 0, 0, 0), "mul_c1");
    step();
    expect_out(MUL_EN ? mk(0, 0, 0, 0, 0, 0, 0, 1) : mk(0, 0, 0, 0, 0, 0, 0, 0), "mul_c2");
    step(); MulOpE = 0;
    expect_out(mk(0, 0, 0, 0, 0, 0, 0, 0), "mul_idle");

    // Multiply with a taken branch: flushes held until the stall clears
    step(); MulOpE = 1; BranchTakenD = 1;
    expect_out(MUL_EN ? mk(0, 0, 1, 1, 1, 0, 0, 0) : mk(0, 0, 0, 0, 0, 1, 1, 0), "mulbr_c0");
    step();
    expect_out(MUL_EN ? mk(0, 0, 1, 1, 1, 0, 0, 1) : mk(0, 0, 0, 0, 0, 1, 1, 0), "mulbr_c1");
    step();
    expect_out(MUL_EN ? mk(0, 0, 0, 0, 0, 1, 1, 1) : mk(0, 0, 0, 0, 0, 1, 1, 0), "mulbr_c2");
    step(); clear_in();
    expect_out(mk(0, 0, 0, 0, 0, 0, 0, 0), "mulbr_idle");

    // Load-use and multiply stall together
    step(); MulOpE = 1; MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5;
    expect_out(MUL_EN ? mk(0, 0, 1, 1, 1, 0, 0, 0) : mk(0, 0, 1, 1, 0, 0, 1, 0), "mulld_c0");
    step(); clear_in(); MulOpE = 1;
    expect_out(MUL_EN ? mk(0, 0, 1, 1, 1, 0, 0, 1) : mk(0, 0, 0, 0, 0, 0, 0, 0), "mulld_c1");
    step();
    expect_out(MUL_EN ? mk(0, 0, 0, 0, 0, 0, 0, 1) : mk(0, 0, 0, 0, 0, 0, 0, 0), "mulld_c2");
    step(); clear_in();
    expect_out(mk(0, 0, 0, 0, 0, 0, 0, 0), "mulld_idle");

    // Reset while busy with cnt=1 abandons the multiply
    step(); MulOpE = 1;
    expect_out(MUL_EN ? mk(0, 0, 1, 1, 1, 0, 0, 0) : mk(0, 0, 0, 0, 0, 0, 0, 0), "rstbusy_start");
    step(); reset = 1; RA1E = 3; WA3M = 3; RegWriteM = 1; PCWrPendingF = 1;
    expect_out(mk(0, 0, 0, 0, 0, 0, 0, 0), "rstbusy_held");
    step(); reset = 0; MulOpE = 0; PCWrPendingF = 0;
    expect_out(mk(2'b10, 0, 0, 0, 0, 0, 0, 0), "rstbusy_release");
    step(); clear_in(); MulOpE = 1;
    expect_out(MUL_EN ? mk(0, 0, 1, 1, 1, 0, 0, 0) : mk(0, 0, 0, 0, 0, 0, 0, 0), "rstbusy_fresh_c0");
    step(); MulOpE = 0;
    expect_out(MUL_EN ? mk(0, 0, 1, 1, 1, 0, 0, 1) : mk(0, 0, 0, 0, 0, 0, 0, 0), "rstbusy_fresh_c1");
    step();
    expect_out(MUL_EN ? mk(0, 0, 0, 0, 0, 0, 0, 1) : mk(0, 0, 0, 0, 0, 0, 0, 0), "rstbusy_fresh_c2");
    step();
    expect_out(mk(0, 0, 0, 0, 0, 0, 0, 0), "rstbusy_idle");

    // Final report
    repeat (3) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
